// File: rtl/tile_map_writer.sv
// tile_map_writer: rectangle/tile writer walking a tile RAM in raster order.
// Optional macro TILE_WRITER_CLIP_EN clips off-screen FILL rectangles instead of rejecting them.
module tile_map_writer #(
  parameter int COLS      = 80,
  parameter int ROWS      = 60,
  parameter int NUM_TILES = 41
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [6:0]  cmd_x,
  input  logic [5:0]  cmd_y,
  input  logic [6:0]  cmd_w,
  input  logic [5:0]  cmd_h,
  input  logic [5:0]  cmd_tile,
  output logic [12:0] ram_addr,
  output logic [5:0]  ram_data,
  output logic        ram_we,
  output logic        busy,
  output logic        err
);
  localparam logic [1:0]  OP_WRITE = 2'b00;
  localparam logic [1:0]  OP_FILL  = 2'b01;
  localparam logic [1:0]  OP_CLEAR = 2'b10;
  localparam logic [7:0]  COLS8    = 8'(COLS);
  localparam logic [7:0]  ROWS8    = 8'(ROWS);
  localparam logic [7:0]  NT8      = 8'(NUM_TILES);
  localparam logic [12:0] COLS13   = 13'(COLS);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [7:0] x0, y0, w0, h0, xe, ye, xl, yl;
  logic [5:0] t0;
  logic       bad, over, empty, acc, start, reject, last_col, last_row;
  logic [7:0] col, row, xs, xl_r, yl_r;
  logic [12:0] base;
  always_comb begin
    x0    = cmd_op == OP_CLEAR ? 8'd0 : {1'b0, cmd_x};
    y0    = cmd_op == OP_CLEAR ? 8'd0 : {2'b0, cmd_y};
    w0    = cmd_op == OP_CLEAR ? COLS8 : cmd_op == OP_WRITE ? 8'd1 : {1'b0, cmd_w};
    h0    = cmd_op == OP_CLEAR ? ROWS8 : cmd_op == OP_WRITE ? 8'd1 : {2'b0, cmd_h};
    t0    = cmd_op == OP_CLEAR ? 6'd0 : cmd_tile;
    xe    = x0 + w0;
    ye    = y0 + h0;
    bad   = cmd_op == 2'b11 ||
            (cmd_op != OP_CLEAR && ({2'b0, cmd_tile} >= NT8 || {1'b0, cmd_x} >= COLS8 || {2'b0, cmd_y} >= ROWS8));
`ifdef TILE_WRITER_CLIP_EN
    over  = 1'b0;
    xl    = (xe > COLS8 ? COLS8 : xe) - 8'd1;
    yl    = (ye > ROWS8 ? ROWS8 : ye) - 8'd1;
`else
    over  = cmd_op == OP_FILL && (xe > COLS8 || ye > ROWS8);
    xl    = xe - 8'd1;
    yl    = ye - 8'd1;
`endif
    empty    = w0 == 8'd0 || h0 == 8'd0;
    cmd_ready = state == IDLE && !reset;
    acc      = cmd_valid && cmd_ready;
    reject   = acc && (bad || over);
    start    = acc && !bad && !over && !empty;
    last_col = col == xl_r;
    last_row = row == yl_r;
    busy     = state == RUN;
    ram_we   = state == RUN;
    state_nx = state == IDLE ? (start ? RUN : IDLE) : (last_col && last_row ? IDLE : RUN);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  // Row base advances by COLS per row so the walk itself needs no multiplier.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col      <= '0;
      row      <= '0;
      xs       <= '0;
      xl_r     <= '0;
      yl_r     <= '0;
      base     <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      err      <= 1'b0;
    end else begin
      err <= reject;
      if (start) begin
        col      <= x0;
        row      <= y0;
        xs       <= x0;
        xl_r     <= xl;
        yl_r     <= yl;
        base     <= 13'(y0) * COLS13;
        ram_addr <= 13'(y0) * COLS13 + 13'(x0);
        ram_data <= t0;
      end else if (state == RUN && !(last_col && last_row)) begin
        if (last_col) begin
          col      <= xs;
          row      <= row + 8'd1;
          base     <= base + COLS13;
          ram_addr <= base + COLS13 + 13'(xs);
        end else begin
          col      <= col + 8'd1;
          ram_addr <= ram_addr + 13'd1;
        end
      end
    end
endmodule

// File: tb/tb_tile_map_writer.sv
// tb_tile_map_writer: directed stimulus against a rectangle-level write model.
module tb_tile_map_writer;
  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int NT   = 41;
  logic        clk = 0;
  logic        reset = 1;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 0;
  logic [6:0]  cmd_x = 0;
  logic [5:0]  cmd_y = 0;
  logic [6:0]  cmd_w = 0;
  logic [5:0]  cmd_h = 0;
  logic [5:0]  cmd_tile = 0;
  logic [12:0] ram_addr;
  logic [5:0]  ram_data;
  logic        ram_we, busy, err;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  typedef struct {int a; int d;} wr_t;
  wr_t q[$];
  int  last_a = 0, last_d = 0;
  bit  exp_err = 0;

  tile_map_writer #(.COLS(COLS), .ROWS(ROWS), .NUM_TILES(NT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_tile(cmd_tile), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .busy(busy), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  // Expands a command into the list of tile writes it must produce; returns the reject flag.
  function automatic bit model_cmd(int op, int x, int y, int w, int h, int t);
    int ex = x, ey = y, ew = w, eh = h, et = t;
    bit rej;
    if (op == 2) begin ex = 0; ey = 0; ew = COLS; eh = ROWS; et = 0; end
    if (op == 0) begin ew = 1; eh = 1; end
    rej = op == 3 || (op != 2 && (t >= NT || x >= COLS || y >= ROWS));
`ifdef TILE_WRITER_CLIP_EN
    if (!rej) begin
      if (ex + ew > COLS) ew = COLS - ex;
      if (ey + eh > ROWS) eh = ROWS - ey;
    end
`else
    if (op == 1 && (x + w > COLS || y + h > ROWS)) rej = 1;
`endif
    if (!rej)
      for (int r = ey; r < ey + eh; r++)
        for (int c = ex; c < ex + ew; c++)
          q.push_back('{r * COLS + c, et});
    return rej;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      last_a = 0;
      last_d = 0;
      exp_err = 0;
    end else begin
      exp_err = 0;
      if (q.size() > 0) begin
        last_a = q[0].a;
        last_d = q[0].d;
        q.delete(0);
      end else if (cmd_valid)
        exp_err = model_cmd(cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_tile);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_we", ram_we, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_data", ram_data, 0);
    end else begin
      chk("we", ram_we, q.size() > 0);
      chk("busy", busy, q.size() > 0);
      chk("ready", cmd_ready, q.size() == 0);
      chk("err", err, exp_err);
      if (q.size() > 0) begin
        chk("addr", ram_addr, q[0].a);
        chk("data", ram_data, q[0].d);
        wr_cnt++;
      end else begin
        chk("addr_hold", ram_addr, last_a);
        chk("data_hold", ram_data, last_d);
      end
    end
  end

  task automatic send(input logic [1:0] op, input int x, input int y, input int w, input int h, input int t);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 10000) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: cmd_ready got 0 expected 1");
    end
    cmd_op = op; cmd_x = 7'(x); cmd_y = 6'(y); cmd_w = 7'(w); cmd_h = 6'(h); cmd_tile = 6'(t);
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 10000) begin @(negedge clk); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int exp_a[4] = '{238, 239, 318, 319};
    int c0, n;
    repeat (3) @(negedge clk);
    #2 reset = 0;
    @(negedge clk);
    #1 chk("ready_after_reset", cmd_ready, 1);
    send(2'b00, 4, 29, 9, 9, 23);
    #1 chk("w1_we", ram_we, 1);
    chk("w1_addr", ram_addr, 2324);
    chk("w1_data", ram_data, 23);
    chk("w1_ready_low", cmd_ready, 0);
    @(negedge clk);
    #1 chk("w1_done_we", ram_we, 0);
    chk("w1_ready_back", cmd_ready, 1);
    send(2'b00, 0, 0, 0, 0, 1);
    send(2'b00, 79, 59, 0, 0, 40);
    #1 chk("w_corner", ram_addr, 4799);
    send(2'b01, 78, 2, 2, 2, 5);
    for (int i = 0; i < 4; i++) begin
      #1 chk("f1_addr", ram_addr, exp_a[i]);
      chk("f1_data", ram_data, 5);
      @(negedge clk);
    end
    #1 chk("f1_ready", cmd_ready, 1);
    send(2'b01, 10, 5, 3, 2, 40);
    wait_idle();
    send(2'b00, 4, 4, 0, 0, 41);
    #1 chk("tile41_err", err, 1);
    chk("tile41_we", ram_we, 0);
    send(2'b11, 1, 1, 1, 1, 1);
    #1 chk("op3_err", err, 1);
    chk("op3_we", ram_we, 0);
    send(2'b00, 80, 0, 0, 0, 1);
    send(2'b01, 0, 60, 1, 1, 1);
    send(2'b01, 5, 5, 0, 3, 7);
    #1 chk("w0_err", err, 0);
    chk("w0_we", ram_we, 0);
    chk("w0_ready", cmd_ready, 1);
    send(2'b01, 5, 5, 3, 0, 7);
    send(2'b01, 79, 59, 3, 3, 7);
`ifdef TILE_WRITER_CLIP_EN
    #1 chk("clip_we", ram_we, 1);
    chk("clip_addr", ram_addr, 4799);
`else
    #1 chk("clip_err", err, 1);
    chk("clip_we", ram_we, 0);
`endif
    wait_idle();
    c0 = wr_cnt;
    send(2'b10, 3, 3, 3, 3, 9);
    #1 chk("clr_first", ram_addr, 0);
    wait_idle();
    chk("clr_count", wr_cnt - c0, 4800);
    chk("clr_last", ram_addr, 4799);
    send(2'b10, 0, 0, 0, 0, 0);
    n = 0;
    while (ram_addr != 1000 && n < 3000) begin @(negedge clk); n++; end
    chk("clr_reach_1000", ram_addr, 1000);
    #2 reset = 1;
    #1 chk("abort_we", ram_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", ram_addr, 0);
    c0 = wr_cnt;
    repeat (3) @(negedge clk);
    #2 reset = 0;
    repeat (5) @(negedge clk);
    chk("abort_no_writes", wr_cnt - c0, 0);
    #1 chk("abort_ready", cmd_ready, 1);
    send(2'b00, 1, 1, 0, 0, 2);
    #1 chk("post_addr", ram_addr, 81);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
